serial_demux_rx: RTL
====================

SERIAL_DEMUX_RX -- requirements
Module: serial_demux_rx

Interface
REQ-001 Parameter DATA_W, default 8, sets the data bits per frame.
REQ-002 Parameter CH_W, default 2, sets the channel-select bits; N = 2**CH_W output channels.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_bit  input  1  serial line; idle level 1.
REQ-006 rx_en  input  1  bit strobe; rx_bit is sampled only on edges where rx_en=1.
REQ-007 ch_data  output  N*DATA_W  per-channel held data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 ch_valid  output  N  per-channel data-valid.
REQ-009 ch_ready  input  N  per-channel consumer accept.
REQ-010 parity_err  output  1  one-cycle pulse: frame dropped on parity mismatch.
REQ-011 frame_err  output  1  one-cycle pulse: frame dropped because the stop bit was 0.
REQ-012 overrun  output  1  one-cycle pulse: frame dropped because the target channel was full.

Function
REQ-013 Frame format, one bit per strobe, in this order:
- start bit 0;
- CH_W channel bits, LSB first;
- DATA_W data bits, LSB first;
- even-parity bit covering the channel and data bits;
- stop bit 1.
REQ-014 FSM states: IDLE, CHAN, DATA, PARITY, STOP, with a bit counter sized for max(CH_W, DATA_W).
REQ-015 IDLE goes to CHAN on a strobed rx_bit=0. A strobed 1 leaves the FSM in IDLE.
REQ-016 CHAN goes to DATA after CH_W strobes. DATA goes to PARITY after DATA_W strobes. PARITY goes to STOP after 1 strobe. STOP goes to IDLE after 1 strobe.
REQ-017 Cycles without rx_en hold all FSM, counter and shift state unchanged.
REQ-018 The frame is evaluated on the STOP strobe, with checks in this priority:
- stop bit = 0: frame_err;
- else parity mismatch: parity_err;
- else target channel full: overrun;
- else deliver.
Only one error pulse is raised per frame.
REQ-019 On delivery, ch_data[ch] and ch_valid[ch] update on the same edge that samples the stop bit. Latency is 0 cycles after the stop strobe edge.
REQ-020 Channel ch is full when ch_valid[ch]=1 and ch_ready[ch]=0 in the delivery cycle.
REQ-021 If ch_valid[ch]=1 and ch_ready[ch]=1 in the delivery cycle, the new data is accepted and ch_valid[ch] stays 1.
REQ-022 ch_valid[k] clears on the edge after ch_valid[k]=1 and ch_ready[k]=1 with no delivery to k. ch_data[k] holds its value.
REQ-023 ch_data[k] SHALL not change while ch_valid[k]=1, except by an accepted delivery per REQ-021.
REQ-024 A dropped frame leaves all ch_data and ch_valid unchanged.
REQ-025 Channels are independent; ch_ready on one channel never affects another.
REQ-026 ch_ready is ignored when the corresponding ch_valid=0.
REQ-027 There is no break detection. After a frame error the FSM returns to IDLE and a new frame starts on the next strobed 0.

Reset
REQ-028 While rst=1, regardless of clk:
- FSM = IDLE, counter = 0;
- ch_valid = 0, ch_data = 0;
- parity_err, frame_err, overrun = 0.
REQ-029 Reset mid-frame discards the partial frame with no error pulse. The first strobed 0 after release starts a new frame.

Structure
REQ-030 Package serial_demux_pkg holds the FSM state enum and default DATA_W / CH_W constants.
REQ-031 Sub-module ch_buffer implements the one-entry holding register with valid/ready for one channel (load, ready, data, valid, full). It is instantiated N times via generate.

Verification
REQ-032 Channel 2, data 0xA5, correct parity, rx_en every cycle -> after the stop-bit edge, ch_valid=0100 and ch_data[2]=0xA5; ch_ready[2]=1 one cycle -> ch_valid=0000.
REQ-033 Channel 1, data 0x3C, parity bit inverted -> parity_err pulses 1 cycle and ch_valid stays 0000.
REQ-034 Channel 0, data 0xFF, stop bit 0 -> frame_err pulses; then a valid frame (ch 3, 0x01) -> ch_data[3]=0x01, ch_valid=1000.
REQ-035 Two frames to channel 0 (0x11 then 0x22) with ch_ready[0]=0 -> overrun pulses and ch_data[0] stays 0x11. Repeat with ch_ready[0]=1 at the second delivery -> ch_data[0]=0x22, ch_valid[0]=1.
REQ-036 rx_en asserted every 4th cycle with channel 3, data 0x5A -> same result as the full-rate run, at 4x the cycle count.
REQ-037 rst pulsed during the DATA state of a channel-1 frame -> no error pulse and ch_valid=0000; a following full frame (ch 1, 0x77) is received correctly.

Source files
------------

// File: rtl/serial_demux_pkg.sv
// Shared types and defaults for the serial demux receiver.
// Holds the receive FSM encoding and default frame widths.
package serial_demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CH_W   = 2;

  typedef enum logic [2:0] {
    IDLE,
    CHAN,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/serial_demux_rx_ch_buffer.sv
// One-entry holding register with valid/ready for a single channel.
// full tells the receiver a delivery now would be dropped.
module ch_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ready,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              full
);

  assign full = valid & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_demux_rx.sv
// Serial frame receiver: start, channel, data, even parity, stop.
// Delivers each good frame into a per-channel holding buffer.
module serial_demux_rx
  import serial_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_bit,
  input  logic                        rx_en,
  output logic [(2**CH_W)*DATA_W-1:0] ch_data,
  output logic [2**CH_W-1:0]          ch_valid,
  input  logic [2**CH_W-1:0]          ch_ready,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int N     = 2**CH_W;
  localparam int MAXW  = (CH_W > DATA_W) ? CH_W : DATA_W;
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   ch_sr;
  logic [DATA_W-1:0] data_sr;
  logic              par;

  logic [CH_W:0]     ch_nx;
  logic [DATA_W:0]   data_nx;
  logic [N-1:0]      ch_full;
  logic [N-1:0]      load;
  logic              deliver;

  always_comb begin
    ch_nx   = {rx_bit, ch_sr};
    data_nx = {rx_bit, data_sr};
    // par is the running XOR of channel, data and parity bits
    deliver = rx_en && (state == STOP) && rx_bit
              && !par && !ch_full[ch_sr];
    load    = deliver ? (N'(1) << ch_sr) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ch_sr      <= '0;
      data_sr    <= '0;
      par        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (rx_en) begin
        unique case (state)
          IDLE: begin
            if (!rx_bit) begin
              state <= CHAN;
              cnt   <= '0;
              par   <= 1'b0;
            end
          end
          CHAN: begin
            ch_sr <= ch_nx[CH_W:1];
            par   <= par ^ rx_bit;
            if (cnt == CNT_W'(CH_W-1)) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            data_sr <= data_nx[DATA_W:1];
            par     <= par ^ rx_bit;
            if (cnt == CNT_W'(DATA_W-1)) begin
              state <= PARITY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            par   <= par ^ rx_bit;
            state <= STOP;
          end
          STOP: begin
            state      <= IDLE;
            frame_err  <= !rx_bit;
            parity_err <= rx_bit && par;
            overrun    <= rx_bit && !par && ch_full[ch_sr];
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
    ch_buffer #(
      .DATA_W(DATA_W)
    ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .ready(ch_ready[k]),
      .din  (data_sr),
      .data (ch_data[k*DATA_W +: DATA_W]),
      .valid(ch_valid[k]),
      .full (ch_full[k])
    );
  end

endmodule
